// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in / parallel-out receiver.
package sipo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam int WIDTH_DEF = 8;

  // Bit-count width; kept at least 1 so degenerate widths still elaborate.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sipo_rx_8.sv
// Reassembles MSB-first serial words gated by the shared sh_ld link control;
// strobes valid on completion and abort when a frame is cut short.
module sipo_rx_8
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sh_ld,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             abort,
  output logic             busy
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    q_d     = q_q;
    valid_d = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sh_ld) begin
          sr_d    = {sr_q[WIDTH-2:0], sin};
          cnt_d   = CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (sh_ld) begin
          sr_d = {sr_q[WIDTH-2:0], sin};
          if (cnt_q == LAST) begin
            // Completion returns to IDLE; IDLE starts the next frame on the
            // very next shift edge, so back-to-back words need no gap.
            q_d     = {sr_q[WIDTH-2:0], sin};
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign abort = abort_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sipo_rx_8.sv
// Directed bench: stimulus queues expected strobes/probes, a negedge monitor checks them.
module tb_sipo_rx_8;

  logic       clk = 1'b0;
  logic       rst, sh_ld, sin;
  logic [7:0] q;
  logic       valid, abort, busy;

  sipo_rx_8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .sh_ld(sh_ld), .sin(sin),
    .q(q), .valid(valid), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    bit         is_abort;
    logic [7:0] q;
  } ev_t;

  typedef struct {
    int         tag;
    logic       busy;
    logic [7:0] q;
    string      name;
  } pr_t;

  ev_t        evq[$];
  pr_t        prq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         done = 1'b0;
  logic [7:0] cur_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sole owner of the check/error counters.
  always @(negedge clk) begin
    ev_t e;
    pr_t p;
    if (valid || abort) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d valid=%0b abort=%0b q=%h (none expected)",
                 cyc, valid, abort, q);
      end else begin
        e = evq.pop_front();
        if (e.tag != cyc || abort != e.is_abort || valid == e.is_abort || q !== e.q) begin
          errors++;
          $display("FAIL event cyc=%0d valid=%0b abort=%0b q=%h, expected cyc=%0d abort=%0b q=%h",
                   cyc, valid, abort, q, e.tag, e.is_abort, e.q);
        end
      end
    end else if (evq.size() != 0 && evq[0].tag <= cyc) begin
      e = evq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event cyc=%0d expected abort=%0b q=%h at cyc=%0d",
               cyc, e.is_abort, e.q, e.tag);
    end
    while (prq.size() != 0 && prq[0].tag <= cyc) begin
      p = prq.pop_front();
      checks++;
      if (p.tag != cyc || busy !== p.busy || q !== p.q) begin
        errors++;
        $display("FAIL %s cyc=%0d busy=%b q=%h, expected busy=%b q=%h at cyc=%0d",
                 p.name, cyc, busy, q, p.busy, p.q, p.tag);
      end
    end
    if (done || cyc > 2000) begin
      checks++;
      if (cyc > 2000) begin
        errors++;
        $display("FAIL timeout cyc=%0d", cyc);
      end else if (evq.size() != 0 || prq.size() != 0) begin
        errors++;
        $display("FAIL leftover events=%0d probes=%0d, expected 0 and 0",
                 evq.size(), prq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic drive(input logic r, input logic s, input logic d);
    rst = r; sh_ld = s; sin = d;
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int ahead, input logic b, input logic [7:0] v, input string n);
    prq.push_back('{tag: cyc + ahead, busy: b, q: v, name: n});
  endtask

  task automatic idle(input string n);
    probe(1, 1'b0, cur_q, n);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [7:0] w, input string n);
    for (int k = 1; k <= 8; k++)
      probe(k, (k < 8), (k < 8) ? cur_q : w, n);
    evq.push_back('{tag: cyc + 8, is_abort: 1'b0, q: w});
    for (int i = 7; i >= 0; i--) drive(1'b0, 1'b1, w[i]);
    cur_q = w;
  endtask

  // First n bits (MSB-first) of w, no completion.
  task automatic partial(input logic [7:0] w, input int n, input string n_s);
    for (int k = 1; k <= n; k++) probe(k, 1'b1, cur_q, n_s);
    for (int i = 7; i > 7 - n; i--) drive(1'b0, 1'b1, w[i]);
  endtask

  initial begin
    cur_q = 8'h00;
    probe(1, 1'b0, 8'h00, "reset1");
    drive(1'b1, 1'b0, 1'b0);
    probe(1, 1'b0, 8'h00, "reset2");
    drive(1'b1, 1'b1, 1'b1);
    idle("load_idle");

    frame(8'hFF, "ff_frame");
    idle("ff_after");

    frame(8'hAA, "aa_frame");
    idle("aa_after");
    idle("aa_idle2");

    frame(8'hA5, "b2b_a5");
    frame(8'h3C, "b2b_3c");
    idle("b2b_after");

    frame(8'hFF, "pre_abort_ff");
    partial(8'hA0, 3, "abort_partial");
    evq.push_back('{tag: cyc + 1, is_abort: 1'b1, q: 8'hFF});
    idle("abort_edge");
    idle("abort_after");
    frame(8'h0F, "post_abort_0f");
    idle("0f_after");

    partial(8'hC3, 5, "rst_partial");
    cur_q = 8'h00;
    probe(1, 1'b0, 8'h00, "mid_rst");
    drive(1'b1, 1'b1, 1'b0);
    idle("mid_rst_after");
    frame(8'hC3, "post_rst_c3");

    partial(8'h96, 7, "cmpl_rst_partial");
    cur_q = 8'h00;
    probe(1, 1'b0, 8'h00, "cmpl_rst");
    drive(1'b1, 1'b1, 1'b0);
    idle("cmpl_rst_after");
    frame(8'h5A, "final_5a");
    idle("final_after");

    done = 1'b1;
  end

endmodule
